mmu_driver: RTL and testbench
=============================

# mmu_driver

Command-driven sequencer on the host side of the MMU tile interface. It accepts one matrix-multiply command, fetches the weight tile and N data tiles from the tile buffer, and pushes them into the MMU. It then loads and optionally swaps weights, runs one multiply per data tile, and pops each result tile into the result buffer. It is the initiator for every MMU handshake: weight push, data push, weight load/swap, multiply run and result pop.

## Interface
- SIZE, 2, tile dimension (SIZE x SIZE)
- ADDR_W, 8, tile-buffer and result-buffer address width, also the tile-count width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_rdy  out  1  high in IDLE only
- cmd_weight_addr / cmd_data_addr / cmd_out_addr  in  ADDR_W each  weight tile, first data tile, first result slot
- cmd_num_tiles  in  ADDR_W  number of data tiles N (0 allowed)
- cmd_swap  in  1  pulse weight_swap after the load completes
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- rd_en / rd_addr  out  1 / ADDR_W  tile-buffer read, rd_data valid exactly 1 cycle later
- rd_data  in  8 x [SIZE][SIZE]  tile read data
- wr_en / wr_addr / wr_data  out  1 / ADDR_W / 32 x [SIZE][SIZE]  result-buffer write
- new_weight_out / new_weight_rdy / new_weight_push  out / in / out  weight tile push
- data_out / data_rdy / data_push  out / in / out  data tile push
- acc_in / acc_rdy / acc_pop  in / in / out  result tile pop; acc_in valid whenever acc_rdy=1
- weight_ld_rdy / weight_ld_start / weight_ld_done  in / out / in  weight load handshake
- weight_swap  out  1  one-cycle swap pulse
- mult_rdy / mult_run / mult_done  in / out / in  multiply handshake; mult_done is ignored

## Operation
- States: IDLE, W_RD, W_CAP, W_PUSH, W_LD, W_WAIT, SWAP, D_RD, D_CAP, D_PUSH, RUN, R_WAIT, R_POP, R_WR, DONE.
- IDLE: cmd_valid && cmd_rdy latches all cmd_* fields and clears tile_cnt, then goes to W_RD. cmd_valid in any other state is ignored.
- W_RD: rd_en=1, rd_addr=weight_addr. -> W_CAP.
- W_CAP: tile_reg <= rd_data. -> W_PUSH.
- W_PUSH: new_weight_out=tile_reg; new_weight_push = new_weight_rdy. -> W_LD on the push.
- W_LD: weight_ld_start = weight_ld_rdy. -> W_WAIT on the start.
- W_WAIT: -> SWAP when weight_ld_done=1.
- SWAP: single cycle; weight_swap = swap_latched. -> DONE if N==0, else D_RD.
- D_RD: rd_en=1, rd_addr = data_addr + tile_cnt, mod 2^ADDR_W. -> D_CAP.
- D_CAP: tile_reg <= rd_data. -> D_PUSH.
- D_PUSH: data_out=tile_reg; data_push = data_rdy. -> RUN on the push.
- RUN: mult_run = mult_rdy. -> R_WAIT on the run.
- R_WAIT: -> R_POP when acc_rdy=1.
- R_POP: acc_pop=1 for one cycle; res_reg <= acc_in. -> R_WR.
- R_WR: wr_en=1, wr_addr = out_addr + tile_cnt (mod 2^ADDR_W), wr_data=res_reg; tile_cnt++. -> DONE if tile_cnt+1 == N, else D_RD.
- DONE: done=1. -> IDLE.
- Data tiles are strictly serial: the next data tile is not pushed until the previous result has been written. This guarantees the MMU is idle when mult_run is asserted.
- Every push/start/run/pop strobe asserts at most one cycle per transfer. A strobe is never asserted while its rdy input is low.

## Timing
- Reset values: all strobes, rd_addr, wr_addr, wr_data, new_weight_out, data_out, done and busy are 0. cmd_rdy=1. State is IDLE.
- Reset asserted in any state returns to IDLE immediately. No partial command resumes after reset. The MMU shares the same reset.
- With no backpressure, command accepted in cycle 0: rd_en in 1, capture in 2, new_weight_push in 3, weight_ld_start earliest in 4.
- After weight_ld_done in cycle k: SWAP in k+1, first data rd_en in k+2, data_push in k+4, mult_run earliest in k+5.
- After acc_rdy is seen: acc_pop is 1 cycle later, wr_en 1 cycle after acc_pop, done 1 cycle after the last wr_en.
- done and cmd_rdy are never high in the same cycle. cmd_rdy returns in the cycle after done.
- Address arithmetic wraps modulo 2^ADDR_W. tile_cnt is ADDR_W bits, so N up to 2^ADDR_W-1.

## Test plan
- SIZE=2, W=[[1,2],[3,4]] at 0x10, X=[[5,6],[7,8]] at 0x20, out=0x40, N=1, swap=1, stub MMU returns acc {100,200,300,400} -> exactly one each of new_weight_push(W), weight_ld_start, weight_swap (after ld_done), data_push(X), mult_run, acc_pop. Then one wr_en at 0x40 with {100,200,300,400}, and done.
- N=3, data_addr=0xFE, out=0xFF -> rd_addr sequence 0x10,0xFE,0xFF,0x00 and wr_addr sequence 0xFF,0x00,0x01. done occurs 1 cycle after the third wr_en.
- new_weight_rdy low for 5 cycles, data_rdy low for 3, mult_rdy low for 2 -> no strobe while its rdy is low, exactly one strobe each once rdy rises, new_weight_out/data_out stable throughout.
- N=0, swap=0 -> weight path only, weight_swap never asserts, no data rd_en, no wr_en, done pulses.
- cmd_valid held high while busy with different fields -> ignored; second command accepted only after done, with its own latched fields.
- rst_n asserted in R_WAIT -> all outputs 0 and cmd_rdy=1 immediately. After release, a fresh N=1 command completes exactly as in scenario 1.

Source files
------------

// File: rtl/mmu_driver.sv
// Host-side sequencer for the MMU tile interface. One command loads a weight
// tile, optionally swaps it in, then streams N data tiles through the MMU one
// at a time, writing each result tile to the result buffer.
//
// Handshake rule: every strobe to the MMU (new_weight_push, data_push,
// weight_ld_start, mult_run) is the AND of "this state wants a transfer" and
// the matching rdy input. A transfer happens in exactly the cycle the strobe
// is high, and the FSM leaves that state on the same edge. As a result, no
// strobe can be high while its rdy input is low, and each transfer produces
// exactly one strobe. acc_pop has no rdy gate because R_POP is only entered
// after acc_rdy has been seen.
module mmu_driver #(
  parameter int SIZE   = 2,
  parameter int ADDR_W = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                cmd_valid,
  output logic                                cmd_rdy,
  input  logic [ADDR_W-1:0]                   cmd_weight_addr,
  input  logic [ADDR_W-1:0]                   cmd_data_addr,
  input  logic [ADDR_W-1:0]                   cmd_out_addr,
  input  logic [ADDR_W-1:0]                   cmd_num_tiles,
  input  logic                                cmd_swap,
  output logic                                busy,
  output logic                                done,
  output logic                                rd_en,
  output logic [ADDR_W-1:0]                   rd_addr,
  input  logic [SIZE-1:0][SIZE-1:0][7:0]      rd_data,
  output logic                                wr_en,
  output logic [ADDR_W-1:0]                   wr_addr,
  output logic [SIZE-1:0][SIZE-1:0][31:0]     wr_data,
  output logic [SIZE-1:0][SIZE-1:0][7:0]      new_weight_out,
  input  logic                                new_weight_rdy,
  output logic                                new_weight_push,
  output logic [SIZE-1:0][SIZE-1:0][7:0]      data_out,
  input  logic                                data_rdy,
  output logic                                data_push,
  input  logic [SIZE-1:0][SIZE-1:0][31:0]     acc_in,
  input  logic                                acc_rdy,
  output logic                                acc_pop,
  input  logic                                weight_ld_rdy,
  output logic                                weight_ld_start,
  input  logic                                weight_ld_done,
  output logic                                weight_swap,
  input  logic                                mult_rdy,
  output logic                                mult_run,
  input  logic                                mult_done,
  output logic [3:0]                          fsm_state
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    W_RD   = 4'd1,
    W_CAP  = 4'd2,
    W_PUSH = 4'd3,
    W_LD   = 4'd4,
    W_WAIT = 4'd5,
    SWAP   = 4'd6,
    D_RD   = 4'd7,
    D_CAP  = 4'd8,
    D_PUSH = 4'd9,
    RUN    = 4'd10,
    R_WAIT = 4'd11,
    R_POP  = 4'd12,
    R_WR   = 4'd13,
    DONE   = 4'd14
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] weight_addr;
  logic [ADDR_W-1:0] data_addr;
  logic [ADDR_W-1:0] out_addr;
  logic [ADDR_W-1:0] num_tiles;
  logic              swap_latched;
  logic [ADDR_W-1:0] tile_cnt;
  logic [ADDR_W-1:0] tile_cnt_inc;
  logic [SIZE-1:0][SIZE-1:0][7:0]  tile_reg;
  logic [SIZE-1:0][SIZE-1:0][31:0] res_reg;

  // The multiply completion flag is not needed: completion is observed
  // through acc_rdy on the result side.
  logic unused_mult_done;
  assign unused_mult_done = mult_done;

  assign tile_cnt_inc = tile_cnt + ADDR_W'(1);
  assign fsm_state    = state;

  // State register; reset aborts any command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: each handshake state advances on its own strobe.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cmd_valid)                 state_nx = W_RD;
      W_RD:                                   state_nx = W_CAP;
      W_CAP:                                  state_nx = W_PUSH;
      W_PUSH:  if (new_weight_rdy)            state_nx = W_LD;
      W_LD:    if (weight_ld_rdy)             state_nx = W_WAIT;
      W_WAIT:  if (weight_ld_done)            state_nx = SWAP;
      SWAP:    state_nx = (num_tiles == '0) ? DONE : D_RD;
      D_RD:                                   state_nx = D_CAP;
      D_CAP:                                  state_nx = D_PUSH;
      D_PUSH:  if (data_rdy)                  state_nx = RUN;
      RUN:     if (mult_rdy)                  state_nx = R_WAIT;
      R_WAIT:  if (acc_rdy)                   state_nx = R_POP;
      R_POP:                                  state_nx = R_WR;
      R_WR:    state_nx = (tile_cnt_inc == num_tiles) ? DONE : D_RD;
      DONE:                                   state_nx = IDLE;
      default:                                state_nx = IDLE;
    endcase
  end

  // Output decode: everything idles at zero outside its own state.
  always_comb begin
    cmd_rdy         = (state == IDLE);
    busy            = (state != IDLE);
    done            = 1'b0;
    rd_en           = 1'b0;
    rd_addr         = '0;
    wr_en           = 1'b0;
    wr_addr         = '0;
    wr_data         = '0;
    new_weight_out  = '0;
    new_weight_push = 1'b0;
    data_out        = '0;
    data_push       = 1'b0;
    acc_pop         = 1'b0;
    weight_ld_start = 1'b0;
    weight_swap     = 1'b0;
    mult_run        = 1'b0;
    case (state)
      W_RD: begin
        rd_en   = 1'b1;
        rd_addr = weight_addr;
      end
      W_PUSH: begin
        new_weight_out  = tile_reg;
        new_weight_push = new_weight_rdy;
      end
      W_LD:   weight_ld_start = weight_ld_rdy;
      SWAP:   weight_swap     = swap_latched;
      D_RD: begin
        rd_en   = 1'b1;
        rd_addr = data_addr + tile_cnt;
      end
      D_PUSH: begin
        data_out  = tile_reg;
        data_push = data_rdy;
      end
      RUN:    mult_run = mult_rdy;
      R_POP:  acc_pop  = 1'b1;
      R_WR: begin
        wr_en   = 1'b1;
        wr_addr = out_addr + tile_cnt;
        wr_data = res_reg;
      end
      DONE:   done = 1'b1;
      default: ;
    endcase
  end

  // Command latch, tile capture, result capture and tile counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_addr  <= '0;
      data_addr    <= '0;
      out_addr     <= '0;
      num_tiles    <= '0;
      swap_latched <= 1'b0;
      tile_cnt     <= '0;
      tile_reg     <= '0;
      res_reg      <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          weight_addr  <= cmd_weight_addr;
          data_addr    <= cmd_data_addr;
          out_addr     <= cmd_out_addr;
          num_tiles    <= cmd_num_tiles;
          swap_latched <= cmd_swap;
          tile_cnt     <= '0;
        end
        W_CAP, D_CAP: tile_reg <= rd_data;
        R_POP:        res_reg  <= acc_in;
        R_WR:         tile_cnt <= tile_cnt_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_driver.sv
// Bench for mmu_driver: a tile-buffer model with one-cycle read latency, a stub
// MMU with configurable backpressure, a monitor that logs every strobe, and a
// table of command vectors with hand-computed expectations.
module tb_mmu_driver;
  localparam int SIZE = 2;
  localparam int AW   = 8;

  typedef logic [SIZE-1:0][SIZE-1:0][7:0]  tile_t;
  typedef logic [SIZE-1:0][SIZE-1:0][31:0] res_t;

  typedef struct {
    logic [7:0] w, d, o, n;
    logic       swap;
    int         nw_low, dr_low, mr_low;
    logic       timing;
    int         wp_dly, dp_dly, run_dly;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0, cmd_rdy, cmd_swap = 1'b0;
  logic [AW-1:0] cmd_weight_addr = '0, cmd_data_addr = '0, cmd_out_addr = '0, cmd_num_tiles = '0;
  logic          busy, done, rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  tile_t         rd_data = '0, new_weight_out, data_out;
  res_t          wr_data, acc_in = '0;
  logic          new_weight_rdy = 1'b1, new_weight_push, data_rdy = 1'b1, data_push;
  logic          acc_rdy = 1'b0, acc_pop, weight_ld_rdy = 1'b1, weight_ld_start, weight_ld_done = 1'b0;
  logic          weight_swap, mult_rdy = 1'b1, mult_run, mult_done = 1'b0;
  logic [3:0]    fsm_state;

  mmu_driver #(.SIZE(SIZE), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_rdy(cmd_rdy),
    .cmd_weight_addr(cmd_weight_addr), .cmd_data_addr(cmd_data_addr),
    .cmd_out_addr(cmd_out_addr), .cmd_num_tiles(cmd_num_tiles), .cmd_swap(cmd_swap),
    .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .new_weight_out(new_weight_out), .new_weight_rdy(new_weight_rdy), .new_weight_push(new_weight_push),
    .data_out(data_out), .data_rdy(data_rdy), .data_push(data_push),
    .acc_in(acc_in), .acc_rdy(acc_rdy), .acc_pop(acc_pop),
    .weight_ld_rdy(weight_ld_rdy), .weight_ld_start(weight_ld_start), .weight_ld_done(weight_ld_done),
    .weight_swap(weight_swap),
    .mult_rdy(mult_rdy), .mult_run(mult_run), .mult_done(mult_done),
    .fsm_state(fsm_state)
  );

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference data ----------------
  function automatic tile_t tile_of(input logic [7:0] a);
    tile_t t;
    if (a == 8'h10) begin
      t[0][0] = 8'd1; t[0][1] = 8'd2; t[1][0] = 8'd3; t[1][1] = 8'd4;
    end else if (a == 8'h20) begin
      t[0][0] = 8'd5; t[0][1] = 8'd6; t[1][0] = 8'd7; t[1][1] = 8'd8;
    end else begin
      for (int r = 0; r < SIZE; r++)
        for (int c = 0; c < SIZE; c++)
          t[r][c] = a + 8'(r * SIZE + c) + 8'h31;
    end
    return t;
  endfunction

  // Result tile k of a command: k=0 gives {100,200,300,400}.
  function automatic res_t acc_of(input int k);
    res_t t;
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        t[r][c] = 32'(k * 1000 + 100 * (r * SIZE + c + 1));
    return t;
  endfunction

  // ---------------- monitor + stub MMU state ----------------
  int cyc = 0;
  int n_acc, n_wpush, n_ldstart, n_swap, n_dpush, n_run, n_pop, n_wr, n_done, viol;
  int cyc_acc, cyc_wpush, cyc_ldstart, cyc_lddone, cyc_swap, cyc_dpush0, cyc_run0;
  int cyc_accrdy, cyc_pop, cyc_wr_last, cyc_done, cyc_done_first;
  logic [7:0] rd_q[$];
  logic [7:0] wr_q[$];
  int         rd_cyc_q[$];
  tile_t      push_q[$];
  logic [127:0] exp_q[$];

  int cfg_nw_low = 0, cfg_dr_low = 0, cfg_mr_low = 0, cfg_ld_dly = 3, cfg_acc_dly = 2;
  int nw_cnt = 0, dr_cnt = 0, mr_cnt = 0, ld_cnt = -1, acc_cnt = -1, pop_idx = 0;
  logic acc_up = 1'b0, acc_seen = 1'b0;
  tile_t nw_prev = '0, d_prev = '0;

  task automatic clear_stats();
    n_acc = 0; n_wpush = 0; n_ldstart = 0; n_swap = 0; n_dpush = 0; n_run = 0;
    n_pop = 0; n_wr = 0; n_done = 0; viol = 0;
    cyc_acc = -1; cyc_wpush = -1; cyc_ldstart = -1; cyc_lddone = -1; cyc_swap = -1;
    cyc_dpush0 = -1; cyc_run0 = -1; cyc_accrdy = -1; cyc_pop = -1; cyc_wr_last = -1;
    cyc_done = -1; cyc_done_first = -1;
    rd_q.delete(); wr_q.delete(); rd_cyc_q.delete(); push_q.delete(); exp_q.delete();
  endtask

  // Samples DUT outputs mid-cycle, then applies the stub's next inputs just
  // after the following rising edge.
  initial begin : monitor
    tile_t nx_rd;
    logic  nx_nwr, nx_dr, nx_mr, nx_ldd, nx_accrdy;
    res_t  nx_acc;
    forever begin
      @(negedge clk);
      cyc++;
      nx_rd = {SIZE*SIZE{8'hEE}};
      if (!rst_n) begin
        nw_cnt = 0; dr_cnt = 0; mr_cnt = 0; ld_cnt = -1; acc_cnt = -1;
        acc_up = 1'b0; acc_seen = 1'b0; nw_prev = '0; d_prev = '0;
      end else begin
        if (cmd_valid && cmd_rdy) begin
          n_acc++; cyc_acc = cyc; pop_idx = 0; nw_cnt = cfg_nw_low;
        end
        if (new_weight_push && !new_weight_rdy) viol++;
        if (data_push && !data_rdy) viol++;
        if (mult_run && !mult_rdy) viol++;
        if (weight_ld_start && !weight_ld_rdy) viol++;
        if (acc_pop && !acc_rdy) viol++;
        if (done && cmd_rdy) viol++;
        if (busy == cmd_rdy) viol++;
        if (nw_prev != '0 && new_weight_out != '0 && new_weight_out != nw_prev) viol++;
        if (d_prev != '0 && data_out != '0 && data_out != d_prev) viol++;
        nw_prev = new_weight_out;
        d_prev  = data_out;
        if (rd_en) begin
          rd_q.push_back(rd_addr); rd_cyc_q.push_back(cyc);
          push_q.push_back(tile_of(rd_addr));
          nx_rd = tile_of(rd_addr);
          dr_cnt = cfg_dr_low;
        end
        if (new_weight_push) begin
          n_wpush++; cyc_wpush = cyc;
          if (push_q.size() == 0) chk("weight_push_unexpected", 1, 0);
          else chk_w("weight_tile", 128'(new_weight_out), 128'(push_q.pop_front()));
        end
        if (data_push) begin
          n_dpush++;
          if (cyc_dpush0 < 0) cyc_dpush0 = cyc;
          if (push_q.size() == 0) chk("data_push_unexpected", 1, 0);
          else chk_w("data_tile", 128'(data_out), 128'(push_q.pop_front()));
          mr_cnt = cfg_mr_low;
        end
        if (weight_ld_start) begin n_ldstart++; cyc_ldstart = cyc; ld_cnt = cfg_ld_dly; end
        if (weight_ld_done) cyc_lddone = cyc;
        if (weight_swap) begin n_swap++; cyc_swap = cyc; end
        if (mult_run) begin
          n_run++;
          if (cyc_run0 < 0) cyc_run0 = cyc;
          acc_cnt = cfg_acc_dly;
        end
        if (acc_rdy && !acc_seen) begin cyc_accrdy = cyc; acc_seen = 1'b1; end
        if (acc_pop) begin
          n_pop++; cyc_pop = cyc; exp_q.push_back(acc_in);
          acc_up = 1'b0; acc_seen = 1'b0; pop_idx++;
        end
        if (wr_en) begin
          n_wr++; cyc_wr_last = cyc; wr_q.push_back(wr_addr);
          if (exp_q.size() == 0) chk("wr_unexpected", 1, 0);
          else chk_w("wr_data", wr_data, exp_q.pop_front());
        end
        if (done) begin
          n_done++; cyc_done = cyc;
          if (cyc_done_first < 0) cyc_done_first = cyc;
        end
      end
      nx_nwr = 1'b1; if (nw_cnt > 0) begin nx_nwr = 1'b0; nw_cnt--; end
      nx_dr  = 1'b1; if (dr_cnt > 0) begin nx_dr  = 1'b0; dr_cnt--; end
      nx_mr  = 1'b1; if (mr_cnt > 0) begin nx_mr  = 1'b0; mr_cnt--; end
      nx_ldd = 1'b0;
      if (ld_cnt == 0) begin nx_ldd = 1'b1; ld_cnt = -1; end
      else if (ld_cnt > 0) ld_cnt--;
      if (acc_cnt == 0) begin acc_up = 1'b1; acc_cnt = -1; end
      else if (acc_cnt > 0) acc_cnt--;
      nx_accrdy = acc_up;
      nx_acc    = acc_up ? acc_of(pop_idx) : '0;
      @(posedge clk);
      #1;
      rd_data = nx_rd; new_weight_rdy = nx_nwr; data_rdy = nx_dr; mult_rdy = nx_mr;
      weight_ld_done = nx_ldd; acc_rdy = nx_accrdy; acc_in = nx_acc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_cmd(input vec_t v);
    cmd_weight_addr = v.w; cmd_data_addr = v.d; cmd_out_addr = v.o;
    cmd_num_tiles = v.n; cmd_swap = v.swap;
  endtask

  task automatic wait_accept(input string name);
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cmd_rdy && cmd_valid) break;
    end
    if (k == 50) chk({name, "_accept_timeout"}, 1, 0);
  endtask

  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == 400) chk({name, "_done_timeout"}, 1, 0);
  endtask

  task automatic run_cmd(input vec_t v, input string name);
    @(posedge clk); #1;
    cfg_nw_low = v.nw_low; cfg_dr_low = v.dr_low; cfg_mr_low = v.mr_low; cfg_acc_dly = 2;
    clear_stats();
    drive_cmd(v);
    cmd_valid = 1'b1;
    wait_accept(name);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_done(name);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_vec(input vec_t v, input string name);
    int n;
    logic [7:0] e;
    n = int'(v.n);
    chk({name, "_accepts"}, n_acc, 1);
    chk({name, "_wpush"}, n_wpush, 1);
    chk({name, "_ldstart"}, n_ldstart, 1);
    chk({name, "_swaps"}, n_swap, v.swap ? 1 : 0);
    if (v.swap) chk({name, "_swap_after_lddone"}, cyc_swap - cyc_lddone, 1);
    chk({name, "_dpush"}, n_dpush, n);
    chk({name, "_run"}, n_run, n);
    chk({name, "_pop"}, n_pop, n);
    chk({name, "_wr"}, n_wr, n);
    chk({name, "_done"}, n_done, 1);
    chk({name, "_rd_count"}, rd_q.size(), n + 1);
    if (rd_q.size() > 0) chk({name, "_rd_w"}, rd_q[0], v.w);
    for (int i = 0; i < n && i + 1 < rd_q.size(); i++) begin
      e = v.d + 8'(i);
      chk({name, "_rd_d"}, rd_q[i + 1], e);
    end
    for (int i = 0; i < n && i < wr_q.size(); i++) begin
      e = v.o + 8'(i);
      chk({name, "_wr_addr"}, wr_q[i], e);
    end
    if (n == 0) chk({name, "_done_after_lddone"}, cyc_done - cyc_lddone, 2);
    else        chk({name, "_done_after_wr"}, cyc_done - cyc_wr_last, 1);
    chk({name, "_wpush_dly"}, cyc_wpush - cyc_acc, v.wp_dly);
    if (n > 0 && rd_cyc_q.size() > 1) begin
      chk({name, "_dpush_dly"}, cyc_dpush0 - rd_cyc_q[1], v.dp_dly);
      chk({name, "_run_dly"}, cyc_run0 - cyc_dpush0, v.run_dly);
    end
    if (v.timing) begin
      chk({name, "_t_rd"}, rd_cyc_q.size() > 0 ? rd_cyc_q[0] - cyc_acc : -1, 1);
      chk({name, "_t_ldstart"}, cyc_ldstart - cyc_acc, 4);
      chk({name, "_t_dpush"}, cyc_dpush0 - cyc_lddone, 4);
      chk({name, "_t_run"}, cyc_run0 - cyc_lddone, 5);
      chk({name, "_t_pop"}, cyc_pop - cyc_accrdy, 1);
      chk({name, "_t_wr"}, cyc_wr_last - cyc_pop, 1);
    end
    chk({name, "_violations"}, viol, 0);
    chk({name, "_leftover_exp"}, exp_q.size() + push_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, "_strobes"}, {busy, done, rd_en, wr_en, new_weight_push, data_push,
                             acc_pop, weight_ld_start, weight_swap, mult_run}, 0);
    chk({name, "_cmd_rdy"}, cmd_rdy, 1);
    chk({name, "_addrs"}, {rd_addr, wr_addr}, 0);
    chk_w({name, "_wr_data"}, wr_data, '0);
    chk_w({name, "_tile_outs"}, 128'({new_weight_out, data_out}), '0);
  endtask

  function automatic vec_t mk(input logic [7:0] w, d, o, n, input logic swap,
                              input int nw, dr, mr, input logic timing,
                              input int wp, dp, rn);
    vec_t v;
    v.w = w; v.d = d; v.o = o; v.n = n; v.swap = swap;
    v.nw_low = nw; v.dr_low = dr; v.mr_low = mr; v.timing = timing;
    v.wp_dly = wp; v.dp_dly = dp; v.run_dly = rn;
    return v;
  endfunction

  // ---------------- main test ----------------
  initial begin : main
    vec_t vecs[5];
    vec_t va, vb;
    int k;
    vecs[0] = mk(8'h10, 8'h20, 8'h40, 8'd1, 1'b1, 0, 0, 0, 1'b1, 3, 2, 1);
    vecs[1] = mk(8'h10, 8'hFE, 8'hFF, 8'd3, 1'b1, 0, 0, 0, 1'b0, 3, 2, 1);
    vecs[2] = mk(8'h10, 8'h20, 8'h40, 8'd1, 1'b1, 5, 3, 2, 1'b0, 6, 4, 3);
    vecs[3] = mk(8'h10, 8'h20, 8'h40, 8'd0, 1'b0, 0, 0, 0, 1'b0, 3, 2, 1);
    vecs[4] = mk(8'h33, 8'h80, 8'h90, 8'd2, 1'b0, 1, 1, 1, 1'b0, 3, 2, 2);
    clear_stats();

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_cmd(vecs[i], $sformatf("vec%0d", i));
      check_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // cmd_valid held through a busy command with different fields
    va = mk(8'h10, 8'h20, 8'h40, 8'd1, 1'b0, 0, 0, 0, 1'b0, 3, 2, 1);
    vb = mk(8'h55, 8'h66, 8'h77, 8'd1, 1'b0, 0, 0, 0, 1'b0, 3, 2, 1);
    @(posedge clk); #1;
    cfg_nw_low = 0; cfg_dr_low = 0; cfg_mr_low = 0; cfg_acc_dly = 2;
    clear_stats();
    drive_cmd(va);
    cmd_valid = 1'b1;
    wait_accept("hold_a");
    @(posedge clk); #1;
    drive_cmd(vb);
    for (k = 0; k < 400; k++) begin
      @(negedge clk); #1;
      if (n_acc >= 2) break;
    end
    if (k == 400) chk("hold_second_accept_timeout", 1, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_done("hold_b");
    repeat (3) @(negedge clk);
    chk("hold_accepts", n_acc, 2);
    chk("hold_done_count", n_done, 2);
    chk("hold_accept_after_done", cyc_acc - cyc_done_first, 1);
    chk("hold_rd_count", rd_q.size(), 4);
    if (rd_q.size() == 4) begin
      chk("hold_rd0", rd_q[0], 8'h10);
      chk("hold_rd1", rd_q[1], 8'h20);
      chk("hold_rd2", rd_q[2], 8'h55);
      chk("hold_rd3", rd_q[3], 8'h66);
    end
    chk("hold_wr_count", wr_q.size(), 2);
    if (wr_q.size() == 2) begin
      chk("hold_wr0", wr_q[0], 8'h40);
      chk("hold_wr1", wr_q[1], 8'h77);
    end
    chk("hold_violations", viol, 0);

    // reset while waiting for a result, then a fresh command
    @(posedge clk); #1;
    clear_stats();
    cfg_acc_dly = 50;
    drive_cmd(vecs[0]);
    cmd_valid = 1'b1;
    wait_accept("rwait");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (n_run >= 1) break;
    end
    if (k == 100) chk("rwait_run_timeout", 1, 0);
    repeat (2) @(negedge clk);
    chk("rwait_busy_before_reset", busy, 1);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("rwait_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cfg_acc_dly = 2;
    repeat (2) @(negedge clk);
    check_idle_outputs("after_reset");
    run_cmd(vecs[0], "post_reset");
    check_vec(vecs[0], "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
